// File: rtl/line_follower_pid.sv
// Clocked line follower: strobed LFA sampling, two-stage classify/PID pipeline,
// follow/node/lost sequencing and H-bridge direction plus PWM duty outputs.
module line_follower_pid #(
  parameter int unsigned ADC_W        = 12,
  parameter int unsigned DUTY_W       = 4,
  parameter int unsigned TH_HI        = 1200,
  parameter int unsigned BASE_DUTY    = 8,
  parameter int          KP           = 1,
  parameter int          KD           = 1,
  parameter int          KI           = 1,
  parameter int unsigned INT_MAX      = 4,
  parameter int unsigned NODE_W       = 4,
  parameter int unsigned NODE_HOLD    = 3,
  parameter int unsigned LOST_SAMPLES = 4
) (
  input  logic              clk_50M,
  input  logic              reset,
  input  logic              enable,
  input  logic              sample_valid,
  input  logic [ADC_W-1:0]  left,
  input  logic [ADC_W-1:0]  middle,
  input  logic [ADC_W-1:0]  right,
  output logic              m1_a,
  output logic              m1_b,
  output logic              m2_a,
  output logic              m2_b,
  output logic [DUTY_W-1:0] dc1,
  output logic [DUTY_W-1:0] dc2,
  output logic [NODE_W-1:0] node_count,
  output logic              node_pulse,
  output logic [1:0]        state
);

  localparam int unsigned CW     = 32;
  localparam int unsigned INT_W  = 16;
  localparam int unsigned HOLD_W = (NODE_HOLD > 0) ? $clog2(NODE_HOLD + 1) : 1;
  localparam int unsigned LOST_W = (LOST_SAMPLES > 0) ? $clog2(LOST_SAMPLES + 1) : 1;

  localparam logic signed [INT_W-1:0] IMAX      = INT_W'(INT_MAX);
  localparam logic signed [INT_W-1:0] IMIN      = -IMAX;
  localparam logic signed [CW-1:0]    BASE_S    = CW'(BASE_DUTY);
  localparam logic signed [CW-1:0]    DMAX_S    = CW'((1 << DUTY_W) - 1);
  localparam logic [DUTY_W-1:0]       BASE_D    = DUTY_W'(BASE_DUTY);
  localparam logic [HOLD_W-1:0]       HOLD_INIT = HOLD_W'(NODE_HOLD);
  localparam logic [LOST_W-1:0]       LOST_LIM  = LOST_W'(LOST_SAMPLES);

  // Direction pins packed as {m1_a, m1_b, m2_a, m2_b}
  localparam logic [3:0] DIR_STOP = 4'b0000;
  localparam logic [3:0] DIR_FWD  = 4'b1010;
  localparam logic [3:0] DIR_PIVR = 4'b1001;
  localparam logic [3:0] DIR_PIVL = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FOLLOW = 2'd1,
    ST_NODE   = 2'd2,
    ST_LOST   = 2'd3
  } state_e;

  function automatic logic [DUTY_W-1:0] sat_duty(input logic signed [CW-1:0] v);
    if (v < 0)           sat_duty = '0;
    else if (v > DMAX_S) sat_duty = DUTY_W'(DMAX_S);
    else                 sat_duty = DUTY_W'(v);
  endfunction

  // ---------------- stage 1: threshold and error classification ----------
  logic              s1_vld_q, s1_vld_d;
  logic signed [2:0] e_q, e_d;
  logic              all_on_q, all_on_d;
  logic              all_off_q, all_off_d;
  logic              on_l, on_m, on_r;

  always_comb begin
    s1_vld_d  = sample_valid;
    e_d       = e_q;
    all_on_d  = all_on_q;
    all_off_d = all_off_q;
    on_l      = left   > ADC_W'(TH_HI);
    on_m      = middle > ADC_W'(TH_HI);
    on_r      = right  > ADC_W'(TH_HI);
    if (sample_valid) begin
      all_on_d  = on_l & on_m & on_r;
      all_off_d = ~(on_l | on_m | on_r);
      case ({on_l, on_m, on_r})
        3'b100:  e_d = -3'sd2;
        3'b110:  e_d = -3'sd1;
        3'b011:  e_d = 3'sd1;
        3'b001:  e_d = 3'sd2;
        default: e_d = 3'sd0;
      endcase
    end
  end

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      s1_vld_q  <= 1'b0;
      e_q       <= '0;
      all_on_q  <= 1'b0;
      all_off_q <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      e_q       <= e_d;
      all_on_q  <= all_on_d;
      all_off_q <= all_off_d;
    end
  end

  // ---------------- stage 2: PID datapath ----------------------------------
  logic signed [INT_W-1:0] integ_q, integ_d;
  logic signed [INT_W-1:0] integ_sum, integ_nxt;
  logic signed [2:0]       prev_q, prev_d;
  logic signed [CW-1:0]    corr;
  logic [DUTY_W-1:0]       duty1, duty2;

  always_comb begin
    integ_sum = integ_q + INT_W'(e_q);
    if (integ_sum > IMAX)      integ_nxt = IMAX;
    else if (integ_sum < IMIN) integ_nxt = IMIN;
    else                       integ_nxt = integ_sum;
    corr  = CW'(KP) * CW'(e_q)
          + CW'(KD) * (CW'(e_q) - CW'(prev_q))
          + CW'(KI) * CW'(integ_nxt);
    duty1 = sat_duty(BASE_S + corr);
    duty2 = sat_duty(BASE_S - corr);
  end

  // ---------------- stage 2: sequencing FSM and output registers ----------
  state_e              state_q, state_d;
  logic                last_neg_q, last_neg_d;
  logic [LOST_W-1:0]   lost_q, lost_d, lost_inc;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [NODE_W-1:0]   node_cnt_q, node_cnt_d;
  logic                node_pulse_q, node_pulse_d;
  logic [3:0]          dir_q, dir_d, pivot;
  logic [DUTY_W-1:0]   dc1_q, dc1_d, dc2_q, dc2_d;
  logic                pid_run;

  always_comb begin
    state_d      = state_q;
    integ_d      = integ_q;
    prev_d       = prev_q;
    last_neg_d   = last_neg_q;
    lost_d       = lost_q;
    hold_d       = hold_q;
    node_cnt_d   = node_cnt_q;
    node_pulse_d = 1'b0;
    dir_d        = dir_q;
    dc1_d        = dc1_q;
    dc2_d        = dc2_q;
    pid_run      = 1'b0;
    lost_inc     = lost_q + LOST_W'(1);
    pivot        = last_neg_q ? DIR_PIVL : DIR_PIVR;

    if (!enable) begin
      state_d    = ST_IDLE;
      integ_d    = '0;
      prev_d     = '0;
      last_neg_d = 1'b0;
      lost_d     = '0;
      hold_d     = '0;
      dir_d      = DIR_STOP;
      dc1_d      = '0;
      dc2_d      = '0;
    end else if (s1_vld_q) begin
      case (state_q)
        // The first enabled sample out of IDLE is handled as a FOLLOW sample
        ST_IDLE, ST_FOLLOW: begin
          if (all_on_q) begin
            state_d      = ST_NODE;
            node_cnt_d   = node_cnt_q + NODE_W'(1);
            node_pulse_d = 1'b1;
            hold_d       = HOLD_INIT;
            integ_d      = '0;
            lost_d       = '0;
            dir_d        = DIR_FWD;
            dc1_d        = BASE_D;
            dc2_d        = BASE_D;
          end else if (all_off_q && (lost_inc >= LOST_LIM)) begin
            state_d = ST_LOST;
            lost_d  = lost_inc;
            integ_d = '0;
            dir_d   = pivot;
            dc1_d   = BASE_D;
            dc2_d   = BASE_D;
          end else begin
            state_d = ST_FOLLOW;
            lost_d  = all_off_q ? lost_inc : '0;
            pid_run = 1'b1;
          end
        end
        ST_NODE: begin
          if ((hold_q == '0) && !all_on_q) begin
            state_d = ST_FOLLOW;
            pid_run = 1'b1;
          end else begin
            if (hold_q != '0) hold_d = hold_q - HOLD_W'(1);
            dir_d = DIR_FWD;
            dc1_d = BASE_D;
            dc2_d = BASE_D;
          end
        end
        ST_LOST: begin
          if (!all_off_q) begin
            state_d = ST_FOLLOW;
            lost_d  = '0;
            pid_run = 1'b1;
          end else begin
            integ_d = '0;
            dir_d   = pivot;
            dc1_d   = BASE_D;
            dc2_d   = BASE_D;
          end
        end
      endcase

      // last_neg remembers the sign of the last nonzero error for LOST pivoting
      if (pid_run) begin
        integ_d = integ_nxt;
        prev_d  = e_q;
        if (e_q != 3'sd0) last_neg_d = e_q[2];
        dir_d   = DIR_FWD;
        dc1_d   = duty1;
        dc2_d   = duty2;
      end
    end
  end

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      integ_q      <= '0;
      prev_q       <= '0;
      last_neg_q   <= 1'b0;
      lost_q       <= '0;
      hold_q       <= '0;
      node_cnt_q   <= '0;
      node_pulse_q <= 1'b0;
      dir_q        <= DIR_STOP;
      dc1_q        <= '0;
      dc2_q        <= '0;
    end else begin
      state_q      <= state_d;
      integ_q      <= integ_d;
      prev_q       <= prev_d;
      last_neg_q   <= last_neg_d;
      lost_q       <= lost_d;
      hold_q       <= hold_d;
      node_cnt_q   <= node_cnt_d;
      node_pulse_q <= node_pulse_d;
      dir_q        <= dir_d;
      dc1_q        <= dc1_d;
      dc2_q        <= dc2_d;
    end
  end

  assign {m1_a, m1_b, m2_a, m2_b} = dir_q;
  assign dc1        = dc1_q;
  assign dc2        = dc2_q;
  assign node_count = node_cnt_q;
  assign node_pulse = node_pulse_q;
  assign state      = state_q;

endmodule

// File: tb/tb_line_follower_pid.sv
// Scoreboard bench for line_follower_pid: a behavioural model predicts each
// sample's response; a monitor compares it two cycles after the strobe.
module tb_line_follower_pid;

  localparam int TH_HI   = 1200;
  localparam int BASE    = 8;
  localparam int KP      = 1;
  localparam int KD      = 1;
  localparam int KI      = 1;
  localparam int INT_MAX = 4;
  localparam int HOLD    = 3;
  localparam int LOSTN   = 4;
  localparam int DMAX    = 15;

  typedef struct packed {
    logic [1:0] st;
    logic [3:0] dir;
    logic [3:0] dc1;
    logic [3:0] dc2;
    logic [3:0] nodes;
    logic       pulse;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset, enable, sample_valid;
  logic [11:0] left, middle, right;
  logic        m1_a, m1_b, m2_a, m2_b;
  logic [3:0]  dc1, dc2, node_count;
  logic        node_pulse;
  logic [1:0]  state;

  line_follower_pid #(
    .ADC_W(12), .DUTY_W(4), .TH_HI(TH_HI), .BASE_DUTY(BASE),
    .KP(KP), .KD(KD), .KI(KI), .INT_MAX(INT_MAX), .NODE_W(4),
    .NODE_HOLD(HOLD), .LOST_SAMPLES(LOSTN)
  ) dut (
    .clk_50M(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
    .left(left), .middle(middle), .right(right),
    .m1_a(m1_a), .m1_b(m1_b), .m2_a(m2_a), .m2_b(m2_b),
    .dc1(dc1), .dc2(dc2), .node_count(node_count), .node_pulse(node_pulse),
    .state(state)
  );

  always #10 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  obs_t exp_q[$];

  // Behavioural model state
  int   m_mode, m_integ, m_prev, m_lost, m_hold, m_nodes;
  bit   m_lastneg;
  obs_t m_out;

  function automatic obs_t dut_obs();
    obs_t o;
    o.st = state; o.dir = {m1_a, m1_b, m2_a, m2_b};
    o.dc1 = dc1; o.dc2 = dc2; o.nodes = node_count; o.pulse = node_pulse;
    return o;
  endfunction

  task automatic chk_obs(input string nm, input obs_t act, input obs_t req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got st=%0d dir=%b dc1=%0d dc2=%0d nodes=%0d pulse=%b, need st=%0d dir=%b dc1=%0d dc2=%0d nodes=%0d pulse=%b",
               nm, act.st, act.dir, act.dc1, act.dc2, act.nodes, act.pulse,
               req.st, req.dir, req.dc1, req.dc2, req.nodes, req.pulse);
    end
  endtask

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d need %0d", nm, act, req);
    end
  endtask

  function automatic int satd(input int v);
    return (v < 0) ? 0 : ((v > DMAX) ? DMAX : v);
  endfunction

  task automatic model_clear(input bit keep_nodes);
    m_mode = 0; m_integ = 0; m_prev = 0; m_lost = 0; m_hold = 0; m_lastneg = 0;
    if (!keep_nodes) m_nodes = 0;
    m_out = '0;
    m_out.nodes = 4'(m_nodes);
  endtask

  // Predicts the registered outputs following one sample
  task automatic model_step(input int lv, input int mv, input int rv);
    bit l, m, r, run_pid;
    int n, e, corr;
    l = (lv > TH_HI); m = (mv > TH_HI); r = (rv > TH_HI);
    n = int'(l) + int'(m) + int'(r);
    // Error is the mean position of the lit sensors (L=-2, M=0, R=+2)
    e = (n == 0 || n == 3) ? 0 : (2 * int'(r) - 2 * int'(l)) / n;
    run_pid = 0;
    m_out.pulse = 1'b0;
    case (m_mode)
      0, 1: begin
        if (n == 3) begin
          m_mode = 2; m_nodes = (m_nodes + 1) % 16; m_out.pulse = 1'b1;
          m_hold = HOLD; m_integ = 0; m_lost = 0;
          m_out.dir = 4'b1010; m_out.dc1 = 4'(BASE); m_out.dc2 = 4'(BASE);
        end else if (n == 0) begin
          m_lost++;
          if (m_lost >= LOSTN) begin
            m_mode = 3; m_integ = 0;
            m_out.dir = m_lastneg ? 4'b0110 : 4'b1001;
            m_out.dc1 = 4'(BASE); m_out.dc2 = 4'(BASE);
          end else begin
            m_mode = 1; run_pid = 1;
          end
        end else begin
          m_lost = 0; m_mode = 1; run_pid = 1;
        end
      end
      2: begin
        if (m_hold == 0 && n != 3) begin
          m_mode = 1; run_pid = 1;
        end else if (m_hold > 0) begin
          m_hold--;
        end
      end
      default: begin
        if (n != 0) begin
          m_mode = 1; m_lost = 0; run_pid = 1;
        end else begin
          m_integ = 0;
          m_out.dir = m_lastneg ? 4'b0110 : 4'b1001;
        end
      end
    endcase
    if (run_pid) begin
      m_integ = m_integ + e;
      if (m_integ > INT_MAX)  m_integ = INT_MAX;
      if (m_integ < -INT_MAX) m_integ = -INT_MAX;
      corr = KP * e + KD * (e - m_prev) + KI * m_integ;
      m_prev = e;
      if (e != 0) m_lastneg = (e < 0);
      m_out.dir = 4'b1010;
      m_out.dc1 = 4'(satd(BASE + corr));
      m_out.dc2 = 4'(satd(BASE - corr));
    end
    m_out.st = 2'(m_mode);
    m_out.nodes = 4'(m_nodes);
    exp_q.push_back(m_out);
  endtask

  // Output due two clocks after each accepted strobe
  logic sv1, sv2;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sv1 <= 1'b0; sv2 <= 1'b0;
    end else begin
      sv1 <= sample_valid; sv2 <= sv1;
    end
  end

  always @(negedge clk) begin
    obs_t req;
    if (sv2) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_underflow: output presented with no expected entry");
      end else begin
        req = exp_q.pop_front();
        chk_obs("sb_out", dut_obs(), req);
      end
    end
  end

  // Caller is at posedge+1; leaves at posedge+1
  task automatic issue(input int lv, input int mv, input int rv, input int gap);
    left = 12'(lv); middle = 12'(mv); right = 12'(rv);
    sample_valid = 1'b1;
    model_step(lv, mv, rv);
    @(posedge clk); #1;
    sample_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    repeat (4) begin @(posedge clk); #1; end
  endtask

  function automatic int rval(input bit on);
    int sel;
    sel = int'($urandom_range(9, 0));
    if (sel == 0) return on ? TH_HI + 1 : TH_HI;
    return on ? int'($urandom_range(4095, TH_HI + 1)) : int'($urandom_range(TH_HI, 0));
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t z;
    reset = 1'b1; enable = 1'b0; sample_valid = 1'b0;
    left = '0; middle = '0; right = '0;
    model_clear(0);
    repeat (3) @(posedge clk);
    #1;
    chk_obs("reset_state", dut_obs(), '0);
    reset = 1'b0; enable = 1'b1;
    @(posedge clk); #1;

    // Centred line, one strobe every 4 cycles
    repeat (3) issue(100, 2000, 100, 3);
    drain();
    chk("centre_dc1", int'(dc1), 8);
    chk("centre_state", int'(state), 1);

    // Right-only: integrator climbs then clamps
    repeat (3) issue(100, 100, 2000, 3);
    drain();
    chk("right_dc1", int'(dc1), 14);
    chk("right_dc2", int'(dc2), 2);

    // Left then right: duty saturates without wrapping
    issue(2000, 100, 100, 1);
    issue(100, 100, 2000, 1);
    drain();
    chk("sat_dc1", int'(dc1), 15);
    chk("sat_dc2", int'(dc2), 0);

    // Persistent node counted once, then released
    repeat (6) issue(2000, 2000, 2000, 1);
    issue(100, 2000, 100, 1);
    drain();
    chk("node_count", int'(node_count), 1);
    chk("node_exit_state", int'(state), 1);

    // Last error -1 then line lost, then recovered
    issue(2000, 2000, 100, 1);
    repeat (4) issue(100, 100, 100, 1);
    drain();
    chk("lost_state", int'(state), 3);
    chk("lost_pivot_l", int'({m1_a, m1_b, m2_a, m2_b}), 4'b0110);
    issue(100, 2000, 100, 1);
    drain();
    chk("recover_state", int'(state), 1);

    // 16 back-to-back node crossings: counter wraps to the same value
    for (int k = 0; k < 16; k++) begin
      issue(2000, 2000, 2000, 0);
      repeat (4) issue(100, 2000, 100, 0);
    end
    drain();
    chk("node_wrap", int'(node_count), 1);

    // Randomised runs of sensor patterns with 0..3 idle cycles between strobes
    for (int k = 0; k < 60; k++) begin
      int pat, len;
      pat = int'($urandom_range(7, 0));
      len = int'($urandom_range(5, 1));
      for (int j = 0; j < len; j++)
        issue(rval(pat[2]), rval(pat[1]), rval(pat[0]), int'($urandom_range(3, 0)));
    end
    repeat (4) issue(100, 2000, 100, 0);
    drain();

    // enable drop forces IDLE on the next clock, node count retained
    enable = 1'b0;
    model_clear(1);
    @(posedge clk); #1;
    chk_obs("disable_idle", dut_obs(), m_out);
    @(posedge clk); #1;
    enable = 1'b1;

    // Reset mid-NODE clears everything asynchronously
    issue(2000, 2000, 2000, 0);
    drain();
    chk("pre_reset_node", int'(state), 2);
    #5 reset = 1'b1;
    #1;
    z = '0;
    chk_obs("async_reset", dut_obs(), z);
    model_clear(0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    issue(100, 2000, 100, 0);
    drain();
    chk("restart_dc1", int'(dc1), 8);

    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
